// File: rtl/fpu_div_pkg.sv
// Shared types and default sizes for the FPU sequential mantissa divider.
package fpu_div_pkg;

  localparam int unsigned DEF_WIDTH = 24;
  localparam int unsigned DEF_FRAC  = 24;
  localparam int unsigned DEF_QW    = DEF_WIDTH + DEF_FRAC;
  localparam int unsigned CNT_W     = $clog2(DEF_QW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mulxbit_div_seq_div_step.sv
// One restoring division iteration: shift in a dividend bit, subtract when it fits.
module div_step #(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH:0]   r,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_nxt_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] dv;
  logic           unused_r_msb;

  // R stays below the divisor, so its top bit is always zero and drops out of T
  assign unused_r_msb = r[WIDTH];
  assign t  = {r[WIDTH-1:0], dbit};
  assign dv = {1'b0, divisor};

  always_comb begin
    q_bit_c = 1'b0;
    r_nxt_c = t;
    if (t >= dv) begin
      q_bit_c = 1'b1;
      r_nxt_c = t - dv;
    end
  end

endmodule

// File: rtl/mulxbit_div_seq.sv
// Sequential radix-2 restoring divider: out = floor((in1 << FRAC) / in2), one quotient bit per clock.
module mulxbit_div_seq
  import fpu_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      in1,
  input  logic [WIDTH-1:0]      in2,
  output logic                  ready,
  output logic                  busy,
  output logic [WIDTH+FRAC-1:0] out,
  output logic [WIDTH-1:0]      rem,
  output logic                  dbz,
  output logic                  done
);

  localparam int unsigned QW = WIDTH + FRAC;
  localparam int unsigned CW = $clog2(QW);

  state_t state, state_nxt;

  logic [CW-1:0]    cnt, cnt_nxt;
  logic [QW-1:0]    d, d_nxt;
  logic [WIDTH:0]   r, r_nxt;
  logic [QW-1:0]    q, q_nxt;
  logic [WIDTH-1:0] dvs, dvs_nxt;
  logic [QW-1:0]    out_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic             dbz_nxt;

  logic [WIDTH:0]   step_r;
  logic             step_q;
  logic             unused_q_msb;

  // The quotient register's MSB is shifted out on the final step, never read
  assign unused_q_msb = q[QW-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r),
    .dbit    (d[cnt]),
    .divisor (dvs),
    .r_nxt_c (step_r),
    .q_bit_c (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = d;
    r_nxt     = r;
    q_nxt     = q;
    dvs_nxt   = dvs;
    out_nxt   = out;
    rem_nxt   = rem;
    dbz_nxt   = dbz;
    case (state)
      IDLE: begin
        if (start) begin
          dvs_nxt = in2;
          if (in2 != '0) begin
            d_nxt     = {in1, {FRAC{1'b0}}};
            r_nxt     = '0;
            q_nxt     = '0;
            cnt_nxt   = CW'(QW - 1);
            state_nxt = RUN;
          end else begin
            out_nxt   = '1;
            rem_nxt   = '0;
            dbz_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        r_nxt = step_r;
        q_nxt = {q[QW-2:0], step_q};
        if (cnt == '0) begin
          out_nxt   = {q[QW-2:0], step_q};
          rem_nxt   = step_r[WIDTH-1:0];
          dbz_nxt   = 1'b0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and status flags; ready/busy/done follow the next state so they stay registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      d     <= '0;
      r     <= '0;
      q     <= '0;
      dvs   <= '0;
      out   <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      d     <= d_nxt;
      r     <= r_nxt;
      q     <= q_nxt;
      dvs   <= dvs_nxt;
      out   <= out_nxt;
      rem   <= rem_nxt;
      dbz   <= dbz_nxt;
      done  <= (state_nxt == DONE);
      ready <= (state_nxt == IDLE);
      busy  <= (state_nxt != IDLE);
    end
  end

endmodule
